// File: rtl/ex_stage_if.sv
// ex_stage_if: bundle between the ID/EX register, the forwarding unit and the
// EX/MEM register around the execute stage.
//   slave  : the execute stage (consumes ID/EX + forwards, drives EX/MEM + stall)
//   master : the surrounding pipeline (drives ID/EX + forwards, observes EX/MEM)
// Signals:
//   flush                         sync kill of the stage
//   reg1_in/reg2_in/imm_in        operands from ID/EX
//   rd_in, alu_ctrl_in, alu_src_in, mem_*_in, reg_write_in   decoded fields
//   fwd_a_sel/fwd_b_sel           00/11 reg, 01 mem_wb_fwd, 10 ex_mem_fwd
//   ex_mem_fwd/mem_wb_fwd         forwarded values
//   *_out                         registered EX/MEM contents
//   stall_out                     hold PC, IF/ID and ID/EX
//   busy_out                      multiplier sequence in progress
interface ex_stage_if #(parameter int XLEN = 32);
    logic            flush;
    logic [XLEN-1:0] reg1_in;
    logic [XLEN-1:0] reg2_in;
    logic [XLEN-1:0] imm_in;
    logic [4:0]      rd_in;
    logic [3:0]      alu_ctrl_in;
    logic            alu_src_in;
    logic            mem_read_in;
    logic            mem_write_in;
    logic            reg_write_in;
    logic            mem_to_reg_in;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [XLEN-1:0] ex_mem_fwd;
    logic [XLEN-1:0] mem_wb_fwd;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic [4:0]      rd_out;
    logic            mem_read_out;
    logic            mem_write_out;
    logic            reg_write_out;
    logic            mem_to_reg_out;
    logic            stall_out;
    logic            busy_out;

    modport master (
        output flush, reg1_in, reg2_in, imm_in, rd_in, alu_ctrl_in, alu_src_in,
               mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in,
               fwd_a_sel, fwd_b_sel, ex_mem_fwd, mem_wb_fwd,
        input  alu_result_out, store_data_out, rd_out, mem_read_out, mem_write_out,
               reg_write_out, mem_to_reg_out, stall_out, busy_out
    );

    modport slave (
        input  flush, reg1_in, reg2_in, imm_in, rd_in, alu_ctrl_in, alu_src_in,
               mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in,
               fwd_a_sel, fwd_b_sel, ex_mem_fwd, mem_wb_fwd,
        output alu_result_out, store_data_out, rd_out, mem_read_out, mem_write_out,
               reg_write_out, mem_to_reg_out, stall_out, busy_out
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Selects forwarded operands, computes single-cycle
// ALU ops, runs an iterative shift-add multiply (XLEN steps) and registers the
// outcome into EX/MEM.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    ex_stage_if.slave (ID/EX fields, forwards, flush in; EX/MEM, stall, busy out)
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);
    localparam int         CW     = $clog2(XLEN);
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store;
        logic [4:0]      rd;
        ctrl_t           ctrl;
    } exmem_t;

    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel, input logic [XLEN-1:0] r,
                                                input logic [XLEN-1:0] exf, input logic [XLEN-1:0] mwf);
        case (sel)
            2'b01:   return mwf;
            2'b10:   return exf;
            default: return r;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, op_bf, op_b, alu_y;
    ctrl_t           ctrl_in;

    assign op_a    = fwd_sel(bus.fwd_a_sel, bus.reg1_in, bus.ex_mem_fwd, bus.mem_wb_fwd);
    assign op_bf   = fwd_sel(bus.fwd_b_sel, bus.reg2_in, bus.ex_mem_fwd, bus.mem_wb_fwd);
    assign op_b    = bus.alu_src_in ? bus.imm_in : op_bf;
    assign ctrl_in = '{bus.mem_read_in, bus.mem_write_in, bus.reg_write_in, bus.mem_to_reg_in};

    // MUL never takes this path; its result comes from the accumulator in DONE.
    always_comb begin
        alu_y = '0;
        case (bus.alu_ctrl_in)
            4'd0: alu_y = op_a + op_b;
            4'd1: alu_y = op_a - op_b;
            4'd2: alu_y = op_a & op_b;
            4'd3: alu_y = op_a | op_b;
            4'd4: alu_y = op_a ^ op_b;
            4'd5: alu_y = op_a << op_b[4:0];
            4'd6: alu_y = op_a >> op_b[4:0];
            4'd7: alu_y = XLEN'($signed(op_a) >>> op_b[4:0]);
            4'd8: alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9: alu_y = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_y = '0;
        endcase
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc, mcand, mplier, pend_bf;
    logic [4:0]      pend_rd;
    ctrl_t           pend_ctrl;
    exmem_t          exmem;
    logic            busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            pend_bf   <= '0;
            pend_rd   <= '0;
            pend_ctrl <= '0;
            exmem     <= '0;
            busy      <= 1'b0;
        end else if (bus.flush) begin
            // Abort any multiply in flight; the partial product is simply abandoned.
            state <= IDLE;
            busy  <= 1'b0;
            exmem <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.alu_ctrl_in == OP_MUL) begin
                        // Latch everything so forwards may change while upstream is stalled.
                        state     <= BUSY;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        acc       <= '0;
                        mcand     <= op_a;
                        mplier    <= op_b;
                        pend_bf   <= op_bf;
                        pend_rd   <= bus.rd_in;
                        pend_ctrl <= ctrl_in;
                        exmem     <= '0;
                    end else begin
                        exmem <= '{result: alu_y, store: op_bf, rd: bus.rd_in, ctrl: ctrl_in};
                    end
                end
                BUSY: begin
                    acc    <= acc + (mcand[0] ? mplier : '0);
                    mcand  <= mcand >> 1;
                    mplier <= mplier << 1;
                    cnt    <= cnt + 1'b1;
                    exmem  <= '0;
                    if (cnt == CW'(XLEN-1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    exmem <= '{result: acc, store: pend_bf, rd: pend_rd, ctrl: pend_ctrl};
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stall covers the MUL issue cycle and every step; DONE releases upstream.
    assign bus.stall_out = !reset && !bus.flush &&
                           ((state == IDLE && bus.alu_ctrl_in == OP_MUL) || state == BUSY);
    assign bus.busy_out       = busy;
    assign bus.alu_result_out = exmem.result;
    assign bus.store_data_out = exmem.store;
    assign bus.rd_out         = exmem.rd;
    assign bus.mem_read_out   = exmem.ctrl.mem_read;
    assign bus.mem_write_out  = exmem.ctrl.mem_write;
    assign bus.reg_write_out  = exmem.ctrl.reg_write;
    assign bus.mem_to_reg_out = exmem.ctrl.mem_to_reg;
endmodule
